// File: rtl/charbuf_ctrl_if.sv
// Keyboard store handshake plus the single char-RAM port owned by charbuf_ctrl.
// The slave modport is the controller's view. The master modport is the view
// of its environment: the keyboard writer together with the RAM.
interface charbuf_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 10
);
    logic          kbd_valid;
    logic          kbd_ready;
    logic [AW-1:0] kbd_addr;
    logic [DW-1:0] kbd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  kbd_valid, kbd_addr, kbd_data, mem_rdata,
        output kbd_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output kbd_valid, kbd_addr, kbd_data, mem_rdata,
        input  kbd_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/charbuf_ctrl.sv
// Character RAM port owner for the 40x15 text display.
// A one-entry keyboard holding buffer shares the RAM port with a sequencer that
// runs CLEAR (zero all cells) and SCROLL (copy rows up by one, blank the last row).
// A keyboard grant stalls the sequencer for one cycle. The only exception is
// SCR_WR, where the copy data read in the previous cycle must be written now.
// The parameters must satisfy COLS*ROWS <= 2**AW.
module charbuf_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 15,
    parameter int AW   = 10,
    parameter int DW   = 10
) (
    input  logic           clk,
    input  logic           rst,
    charbuf_ctrl_if.slave  bus,
    input  logic           clear_cmd,
    input  logic           scroll_cmd,
    output logic           busy,
    output logic           done
);

    localparam int CELLS     = COLS * ROWS;
    localparam int COPY_LAST = COLS * (ROWS - 1) - 1;

    localparam logic [AW-1:0] IDX_ZERO      = AW'(0);
    localparam logic [AW-1:0] IDX_ONE       = AW'(1);
    localparam logic [AW-1:0] IDX_LAST      = AW'(CELLS - 1);
    localparam logic [AW-1:0] IDX_COPY_LAST = AW'(COPY_LAST);
    localparam logic [AW-1:0] ROW_STRIDE    = AW'(COLS);
    localparam logic [DW-1:0] BLANK         = DW'(0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLR      = 3'd1,
        SCR_RD   = 3'd2,
        SCR_WR   = 3'd3,
        SCR_FILL = 3'd4
    } state_t;

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic          buf_full_r;
    logic [AW-1:0] buf_addr_r;
    logic [DW-1:0] buf_data_r;

    logic          load_s;
    logic          grant_s;

    // The buffer accepts a new store only when it is empty.
    assign bus.kbd_ready = !buf_full_r;
    assign load_s        = bus.kbd_valid && !buf_full_r;

    // A buffered store gets the port except in SCR_WR. While rst is high the
    // buffered store is suppressed, because reset discards it.
    assign grant_s = buf_full_r && (state_r != SCR_WR) && !rst;

    assign busy = (state_r != IDLE);

    // Sequencer state, cell index, keyboard holding buffer and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= IDX_ZERO;
            buf_full_r <= 1'b0;
            buf_addr_r <= IDX_ZERO;
            buf_data_r <= BLANK;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (load_s) begin
                buf_full_r <= 1'b1;
                buf_addr_r <= bus.kbd_addr;
                buf_data_r <= bus.kbd_data;
            end else if (grant_s) begin
                buf_full_r <= 1'b0;
            end else begin
                buf_full_r <= buf_full_r;
            end

            // IDLE does not use the RAM port, so a grant there never drops a
            // command pulse. Port-using states hold for one cycle on a grant.
            if (state_r == IDLE) begin
                if (clear_cmd) begin
                    state_r <= CLR;
                    idx_r   <= IDX_ZERO;
                end else if (scroll_cmd) begin
                    state_r <= SCR_RD;
                    idx_r   <= IDX_ZERO;
                end else begin
                    state_r <= IDLE;
                end
            end else if (grant_s) begin
                state_r <= state_r;
                idx_r   <= idx_r;
            end else begin
                case (state_r)
                    CLR: begin
                        if (idx_r == IDX_LAST) begin
                            state_r <= IDLE;
                            idx_r   <= IDX_ZERO;
                            done    <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                    SCR_RD: begin
                        state_r <= SCR_WR;
                    end
                    SCR_WR: begin
                        idx_r <= idx_r + IDX_ONE;
                        if (idx_r == IDX_COPY_LAST) begin
                            state_r <= SCR_FILL;
                        end else begin
                            state_r <= SCR_RD;
                        end
                    end
                    SCR_FILL: begin
                        if (idx_r == IDX_LAST) begin
                            state_r <= IDLE;
                            idx_r   <= IDX_ZERO;
                            done    <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        idx_r   <= IDX_ZERO;
                    end
                endcase
            end
        end
    end

    // RAM port mux: a keyboard grant first, then the sequencer's access for its state
    always_comb begin
        bus.mem_addr  = IDX_ZERO;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = BLANK;
        if (grant_s) begin
            bus.mem_addr  = buf_addr_r;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = buf_data_r;
        end else if (rst) begin
            bus.mem_addr  = IDX_ZERO;
            bus.mem_we    = 1'b0;
            bus.mem_wdata = BLANK;
        end else begin
            case (state_r)
                CLR: begin
                    bus.mem_addr  = idx_r;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = BLANK;
                end
                SCR_RD: begin
                    bus.mem_addr  = idx_r + ROW_STRIDE;
                    bus.mem_we    = 1'b0;
                    bus.mem_wdata = BLANK;
                end
                SCR_WR: begin
                    bus.mem_addr  = idx_r;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.mem_rdata;
                end
                SCR_FILL: begin
                    bus.mem_addr  = idx_r;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = BLANK;
                end
                default: begin
                    bus.mem_addr  = IDX_ZERO;
                    bus.mem_we    = 1'b0;
                    bus.mem_wdata = BLANK;
                end
            endcase
        end
    end

endmodule
